// File: rtl/branch_resolve_unit.sv
// EXE-stage branch checker: compares the carried-down prediction with the resolved outcome,
// emits a registered predictor update record and a delay-slot-aware fetch redirect.
module branch_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    input  logic             exe_stall,
    input  logic [31:0]      exe_pc,
    input  logic [1:0]       exe_type,
    input  logic             exe_taken,
    input  logic [31:0]      exe_target,
    input  logic             pred_valid,
    input  logic             pred_taken,
    input  logic [31:0]      pred_target,
    input  logic             pred_hit,
    input  logic [1:0]       pred_count,
    input  logic             id_valid,
    input  logic             exc_flush,
    output logic             bres_valid,
    output logic [31:0]      bres_pc,
    output logic [31:0]      bres_target,
    output logic [1:0]       bres_type,
    output logic             bres_taken,
    output logic             bres_hit,
    output logic [1:0]       bres_count,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mp_cnt
);

    typedef enum logic {IDLE, WAIT_DS} state_t;

    state_t      state;
    logic [31:0] held_pc;
    logic        raw_resolve;
    logic        resolve;
    logic        mispredict;
    logic [31:0] correct_pc;

    // A branch reaching EXE while a redirect is still waiting for its delay slot is dropped.
    always_comb begin
        // NOTE: every combinational output is assigned on every path so no latch is inferred.
        raw_resolve = exe_valid & ~exe_stall & (exe_type != 2'b00) & ~exc_flush;
        resolve     = raw_resolve & (state == IDLE);
        correct_pc  = exe_taken ? exe_target : exe_pc + 32'd8;
        mispredict  = resolve & (~pred_valid | (pred_taken != exe_taken)
                                 | (exe_taken & (pred_target != exe_target)));
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; it is sampled only on the clock edge like any other input.
        if (rst) begin
            state          <= IDLE;
            held_pc        <= '0;
            bres_valid     <= 1'b0;
            bres_pc        <= '0;
            bres_target    <= '0;
            bres_type      <= '0;
            bres_taken     <= 1'b0;
            bres_hit       <= 1'b0;
            bres_count     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            perf_br_cnt    <= '0;
            perf_mp_cnt    <= '0;
        end else begin
            assert (!(raw_resolve && state == WAIT_DS));

            bres_valid <= resolve;
            if (resolve) begin
                bres_pc     <= exe_pc;
                bres_target <= exe_target;
                bres_type   <= exe_type;
                bres_taken  <= exe_taken;
                bres_hit    <= pred_hit;
                bres_count  <= pred_count;
            end

            redirect_valid <= 1'b0;
            if (exc_flush) begin
                state   <= IDLE;
                held_pc <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mispredict) begin
                            if (id_valid) begin
                                redirect_valid <= 1'b1;
                                redirect_pc    <= correct_pc;
                            end else begin
                                held_pc <= correct_pc;
                                state   <= WAIT_DS;
                            end
                        end
                    end
                    WAIT_DS: begin
                        if (id_valid) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= held_pc;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (resolve && perf_br_cnt != '1)
                perf_br_cnt <= perf_br_cnt + 1'b1;
            if (mispredict && perf_mp_cnt != '1)
                perf_mp_cnt <= perf_mp_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit against a cycle-level behavioural model.
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             exe_valid, exe_stall, exe_taken;
    logic [31:0]      exe_pc, exe_target;
    logic [1:0]       exe_type;
    logic             pred_valid, pred_taken, pred_hit;
    logic [31:0]      pred_target;
    logic [1:0]       pred_count;
    logic             id_valid, exc_flush;
    logic             bres_valid, bres_taken, bres_hit, redirect_valid;
    logic [31:0]      bres_pc, bres_target, redirect_pc;
    logic [1:0]       bres_type, bres_count;
    logic [CNT_W-1:0] perf_br_cnt, perf_mp_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_wait;
    logic [31:0] m_held;
    int          m_br, m_mp;
    logic        e_bv, e_bt, e_bh, e_rv;
    logic [31:0] e_bpc, e_btgt, e_rpc;
    logic [1:0]  e_bty, e_bc;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_stall(exe_stall), .exe_pc(exe_pc), .exe_type(exe_type),
        .exe_taken(exe_taken), .exe_target(exe_target),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_hit(pred_hit), .pred_count(pred_count),
        .id_valid(id_valid), .exc_flush(exc_flush),
        .bres_valid(bres_valid), .bres_pc(bres_pc), .bres_target(bres_target),
        .bres_type(bres_type), .bres_taken(bres_taken), .bres_hit(bres_hit),
        .bres_count(bres_count), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_br_cnt(perf_br_cnt), .perf_mp_cnt(perf_mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_held = '0; m_br = 0; m_mp = 0;
        e_bv = 0; e_bt = 0; e_bh = 0; e_rv = 0;
        e_bpc = '0; e_btgt = '0; e_rpc = '0; e_bty = '0; e_bc = '0;
    endtask

    // Advance one clock: predict the outputs from the spec rules, then compare after the edge.
    task automatic tick();
        bit          res, mp;
        logic [31:0] cpc;
        res = exe_valid && !exe_stall && exe_type != 2'b00 && !exc_flush && !m_wait;
        cpc = exe_taken ? exe_target : exe_pc + 32'd8;
        mp  = res && (!pred_valid || pred_taken != exe_taken
                      || (exe_taken && pred_target != exe_target));
        e_bv = res;
        if (res) begin
            e_bpc = exe_pc; e_btgt = exe_target; e_bty = exe_type;
            e_bt = exe_taken; e_bh = pred_hit; e_bc = pred_count;
        end
        e_rv = 0;
        if (exc_flush) m_wait = 0;
        else if (m_wait) begin
            if (id_valid) begin e_rv = 1; e_rpc = m_held; m_wait = 0; end
        end else if (mp) begin
            if (id_valid) begin e_rv = 1; e_rpc = cpc; end
            else begin m_wait = 1; m_held = cpc; end
        end
        if (res && m_br < CMAX) m_br++;
        if (mp && m_mp < CMAX) m_mp++;
        if (rst) model_reset();
        @(posedge clk);
        #1;
        check("bres_valid",     32'(bres_valid),     32'(e_bv));
        check("bres_pc",        bres_pc,             e_bpc);
        check("bres_target",    bres_target,         e_btgt);
        check("bres_type",      32'(bres_type),      32'(e_bty));
        check("bres_taken",     32'(bres_taken),     32'(e_bt));
        check("bres_hit",       32'(bres_hit),       32'(e_bh));
        check("bres_count",     32'(bres_count),     32'(e_bc));
        check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        check("redirect_pc",    redirect_pc,         e_rpc);
        check("perf_br_cnt",    32'(perf_br_cnt),    32'(m_br));
        check("perf_mp_cnt",    32'(perf_mp_cnt),    32'(m_mp));
    endtask

    task automatic idle_in();
        exe_valid = 0; exe_stall = 0; exe_type = 2'b00; exe_taken = 0;
        exe_pc = '0; exe_target = '0; pred_valid = 0; pred_taken = 0;
        pred_target = '0; pred_hit = 0; pred_count = '0; exc_flush = 0;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                          input logic idv);
        exe_valid = 1; exe_stall = 0; exe_pc = pc; exe_type = ty; exe_taken = tk;
        exe_target = tgt; pred_valid = 1; pred_taken = pt; pred_target = ptgt;
        pred_hit = 1; pred_count = 2'b10; id_valid = idv; exc_flush = 0;
    endtask

    initial begin
        model_reset();
        idle_in();
        id_valid = 1;
        rst = 1;
        tick(); tick();
        check("reset_bres_valid", 32'(bres_valid), 32'd0);
        check("reset_mp_cnt", 32'(perf_mp_cnt), 32'd0);
        rst = 0;
        tick();

        // 1: correctly predicted taken branch
        branch(32'h8000_0100, 2'b01, 1, 32'h8000_0200, 1, 32'h8000_0200, 1);
        tick();
        check("t1_bres_valid", 32'(bres_valid), 32'd1);
        check("t1_redirect", 32'(redirect_valid), 32'd0);
        check("t1_br_cnt", 32'(perf_br_cnt), 32'd1);
        idle_in(); tick();
        check("t1_bres_one_cycle", 32'(bres_valid), 32'd0);

        // 2: predicted taken, actually not taken, delay slot present
        branch(32'h8000_0100, 2'b01, 0, 32'h8000_0200, 1, 32'h8000_0200, 1);
        tick();
        check("t2_redirect", 32'(redirect_valid), 32'd1);
        check("t2_redirect_pc", redirect_pc, 32'h8000_0108);
        check("t2_mp_cnt", 32'(perf_mp_cnt), 32'd1);
        idle_in(); tick();

        // 3: mispredict while delay slot missing for 3 cycles
        branch(32'h8000_0300, 2'b01, 1, 32'h8000_0400, 0, 32'h0, 0);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_redirect", 32'(redirect_valid), 32'd0);
        end
        id_valid = 1;
        tick();
        check("t3_redirect_pc", redirect_pc, 32'h8000_0400);
        tick();

        // 4: return with wrong RAS target; stalled cycle first
        branch(32'h8000_0010, 2'b11, 1, 32'h8000_0050, 1, 32'h8000_0040, 1);
        exe_stall = 1;
        tick();
        exe_stall = 0;
        tick();
        check("t4_redirect_pc", redirect_pc, 32'h8000_0050);
        check("t4_bres_type", 32'(bres_type), 32'd3);
        idle_in(); tick();

        // 5: flush in WAIT_DS, then flush in the resolve cycle
        branch(32'h8000_0500, 2'b01, 0, 32'h8000_0600, 1, 32'h8000_0600, 0);
        tick();
        idle_in(); exc_flush = 1; tick();
        exc_flush = 0; id_valid = 1; tick();
        check("t5_no_redirect", 32'(redirect_valid), 32'd0);
        branch(32'h8000_0700, 2'b01, 0, 32'h8000_0800, 1, 32'h8000_0800, 1);
        exc_flush = 1;
        tick();
        check("t5_no_bres", 32'(bres_valid), 32'd0);
        idle_in(); tick();

        // rst while waiting for the delay slot
        branch(32'h8000_0900, 2'b10, 1, 32'h8000_0a00, 0, 32'h0, 0);
        tick();
        idle_in(); rst = 1; tick();
        rst = 0; id_valid = 1; tick();
        check("rst_wait_no_redirect", 32'(redirect_valid), 32'd0);

        // 6: saturate the mispredict counter
        for (int i = 0; i < CMAX + 2; i++) begin
            branch(32'h8000_1000 + 32'(i * 4), 2'b01, 1, 32'h8000_2000, 0, 32'h0, 1);
            tick();
        end
        idle_in(); tick();
        check("t6_mp_saturated", 32'(perf_mp_cnt), 32'(CMAX));

        // randomized traffic; no branch presented while a redirect waits for its delay slot
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            tg = 32'h8000_0000 + 32'($urandom_range(0, 3) * 16);
            exe_valid   = ($urandom_range(0, 3) != 0);
            exe_stall   = ($urandom_range(0, 4) == 0);
            exe_type    = m_wait ? 2'b00 : 2'($urandom_range(0, 3));
            exe_taken   = (exe_type[1]) ? 1'b1 : 1'($urandom);
            exe_pc      = $urandom;
            exe_target  = tg;
            pred_valid  = ($urandom_range(0, 5) != 0);
            pred_taken  = 1'($urandom);
            pred_target = ($urandom_range(0, 2) != 0) ? tg
                          : 32'h8000_0000 + 32'($urandom_range(0, 3) * 16);
            pred_hit    = 1'($urandom);
            pred_count  = 2'($urandom);
            id_valid    = ($urandom_range(0, 9) < 7);
            exc_flush   = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
